// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - Core-side and memory-side signal bundle for mem_port_arbiter
//
// Purpose: groups the fetch port (i_*), data port (d_*) and shared memory bus
// (m_*) used by mem_port_arbiter into one interface.
//
// Modports:
//   slave  - the arbiter's view: requester inputs, ready/rdata outputs,
//            shared-bus outputs, m_rdata/m_ack inputs.
//   master - the surrounding system's view (pipeline plus memory): the mirror
//            image of slave.
//
// Signals:
//   i_req, i_addr, i_ready, i_rdata                  fetch port
//   d_req, d_we, d_addr, d_wdata, d_wmask,
//   d_ready, d_rdata                                 data port
//   m_req, m_we, m_addr, m_wdata, m_wmask,
//   m_rdata, m_ack                                   shared memory bus
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_wmask;
  logic                d_ready;
  logic [DATA_W-1:0]   d_rdata;

  logic                m_req;
  logic                m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wmask;
  logic [DATA_W-1:0]   m_rdata;
  logic                m_ack;

  modport slave (
    input  i_req, i_addr,
    output i_ready, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wmask,
    output d_ready, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_wmask,
    input  m_rdata, m_ack
  );

  modport master (
    output i_req, i_addr,
    input  i_ready, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wmask,
    input  d_ready, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_wmask,
    output m_rdata, m_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Non-pipelined IF/MEM arbiter for one single-ported memory bus
//
// Purpose: shares one memory bus between instruction fetch and load/store.
// One transaction outstanding at a time; every shared-bus and requester-side
// output is a register. Data requests win by default because the MEM-stage
// instruction is older than the one being fetched.
//
// Optional feature (macro ARB_STARVE_EN): a saturating counter of D grants
// made while a fetch was waiting; once it reaches STARVE_MAX the next IDLE
// grant goes to the fetch port even if d_req is high. Without the macro
// there is no counter and D always wins.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   bus    slave modport of mem_port_arbiter_if:
//            i_req/i_addr in, i_ready/i_rdata out         fetch port
//            d_req/d_we/d_addr/d_wdata/d_wmask in,
//            d_ready/d_rdata out                          data port
//            m_req/m_we/m_addr/m_wdata/m_wmask out,
//            m_rdata/m_ack in                             shared memory bus
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  state_t              state_q;
  logic                owner_q;
  logic                m_req_q;
  logic                m_we_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_wdata_q;
  logic [DATA_W/8-1:0] m_wmask_q;
  logic                i_ready_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic                d_ready_q;
  logic [DATA_W-1:0]   d_rdata_q;

  // Side that would win if arbitration happened this cycle.
  logic grant_i_d;
  logic any_req;

  assign any_req = bus.i_req | bus.d_req;

  // A zero or negative cap would make the fetch port always win; refuse it.
  if (STARVE_MAX < 1) begin : g_starve_max_invalid
    starve_max_must_be_positive u_cfg_error ();
  end

`ifdef ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_CAP = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q;
  logic          starve_force;

  assign starve_force = (starve_q >= STARVE_CAP);

  always_comb begin
    grant_i_d = 1'b0;
    if (bus.i_req && (!bus.d_req || starve_force)) begin
      grant_i_d = 1'b1;
    end
  end

  // Counter only moves on IDLE grants: +1 (saturating) when D wins over a
  // waiting fetch, cleared whenever I is granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (state_q == ST_IDLE && any_req) begin
      if (grant_i_d) begin
        starve_q <= '0;
      end else if (bus.i_req && starve_q != STARVE_CAP) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end
`else
  always_comb begin
    grant_i_d = 1'b0;
    if (bus.i_req && !bus.d_req) begin
      grant_i_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWNER_I;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wmask_q <= '0;
      i_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_ready_q <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            m_req_q <= 1'b1;
            state_q <= ST_BUS;
            if (grant_i_d) begin
              owner_q   <= OWNER_I;
              m_we_q    <= 1'b0;
              m_addr_q  <= bus.i_addr;
              m_wdata_q <= '0;
              m_wmask_q <= '0;
            end else begin
              owner_q   <= OWNER_D;
              m_we_q    <= bus.d_we;
              m_addr_q  <= bus.d_addr;
              m_wdata_q <= bus.d_wdata;
              // Loads never carry a byte mask onto the bus.
              m_wmask_q <= bus.d_we ? bus.d_wmask : '0;
            end
          end
        end

        ST_BUS: begin
          // m_* fields are left untouched until the next grant; only m_req
          // drops when the memory acknowledges.
          if (bus.m_ack) begin
            m_req_q <= 1'b0;
            state_q <= ST_RESP;
            if (owner_q == OWNER_D) begin
              d_ready_q <= 1'b1;
              d_rdata_q <= m_we_q ? '0 : bus.m_rdata;
            end else begin
              i_ready_q <= 1'b1;
              i_rdata_q <= bus.m_rdata;
            end
          end
        end

        ST_RESP: begin
          // No arbitration here: gives the requester one cycle to drop or
          // change its request before it can be granted again.
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          state_q   <= ST_IDLE;
        end

        default: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          m_req_q   <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_wmask = m_wmask_q;
  assign bus.i_ready = i_ready_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_ready = d_ready_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_addr;

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_wmask = '0;
    bus.m_rdata = '0;
    bus.m_ack   = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_m_req",   64'(bus.m_req),   64'h0);
    chk("rst_m_addr",  64'(bus.m_addr),  64'h0);
    chk("rst_m_wmask", 64'(bus.m_wmask), 64'h0);
    chk("rst_i_ready", 64'(bus.i_ready), 64'h0);
    chk("rst_d_ready", 64'(bus.d_ready), 64'h0);
    chk("rst_i_rdata", 64'(bus.i_rdata), 64'h0);
    chk("rst_d_rdata", 64'(bus.d_rdata), 64'h0);
    reset = 1'b1;
    tick();

    // Lone fetch, zero-wait memory
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h1C00_0000;
    tick();
    chk("f_m_req",   64'(bus.m_req),   64'h1);
    chk("f_m_addr",  64'(bus.m_addr),  64'h1C00_0000);
    chk("f_m_we",    64'(bus.m_we),    64'h0);
    chk("f_i_ready0", 64'(bus.i_ready), 64'h0);
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h0280_0413;
    tick();
    chk("f_i_ready", 64'(bus.i_ready), 64'h1);
    chk("f_i_rdata", 64'(bus.i_rdata), 64'h0280_0413);
    chk("f_m_req_drop", 64'(bus.m_req), 64'h0);
    chk("f_d_ready", 64'(bus.d_ready), 64'h0);
    bus.m_ack = 1'b0;
    bus.i_req = 1'b0;
    tick();
    chk("f_i_ready_end", 64'(bus.i_ready), 64'h0);
    chk("f_i_rdata_hold", 64'(bus.i_rdata), 64'h0280_0413);

    // Store, ack after 3 wait cycles
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h1C00_1000;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_wmask = 4'hF;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("st_m_req",   64'(bus.m_req),   64'h1);
      chk("st_m_we",    64'(bus.m_we),    64'h1);
      chk("st_m_addr",  64'(bus.m_addr),  64'h1C00_1000);
      chk("st_m_wdata", 64'(bus.m_wdata), 64'hDEAD_BEEF);
      chk("st_m_wmask", 64'(bus.m_wmask), 64'hF);
      chk("st_d_ready0", 64'(bus.d_ready), 64'h0);
      if (k < 3) tick();
    end
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h1234_5678;
    tick();
    chk("st_d_ready", 64'(bus.d_ready), 64'h1);
    chk("st_d_rdata", 64'(bus.d_rdata), 64'h0);
    chk("st_m_req_drop", 64'(bus.m_req), 64'h0);
    bus.m_ack = 1'b0;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    chk("st_d_ready_end", 64'(bus.d_ready), 64'h0);

    // Collision: D (load) wins, then I
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h0000_0200;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0000_0100;
    bus.d_wmask = 4'hF;
    tick();
    chk("col_d_addr",  64'(bus.m_addr),  64'h100);
    chk("col_d_we",    64'(bus.m_we),    64'h0);
    chk("col_d_wmask", 64'(bus.m_wmask), 64'h0);
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h55;
    tick();
    chk("col_d_ready", 64'(bus.d_ready), 64'h1);
    chk("col_d_rdata", 64'(bus.d_rdata), 64'h55);
    chk("col_i_ready0", 64'(bus.i_ready), 64'h0);
    bus.m_ack = 1'b0;
    bus.d_req = 1'b0;
    tick();
    chk("col_resp_no_req", 64'(bus.m_req), 64'h0);
    chk("col_d_ready_end", 64'(bus.d_ready), 64'h0);
    tick();
    chk("col_i_m_req",  64'(bus.m_req),  64'h1);
    chk("col_i_m_addr", 64'(bus.m_addr), 64'h200);
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'hAA;
    tick();
    chk("col_i_ready", 64'(bus.i_ready), 64'h1);
    chk("col_i_rdata", 64'(bus.i_rdata), 64'hAA);
    chk("col_d_rdata_hold", 64'(bus.d_rdata), 64'h55);
    bus.m_ack = 1'b0;
    bus.i_req = 1'b0;
    tick();

    // Spurious ack in IDLE
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'hFFFF_FFFF;
    tick();
    chk("sp_m_req",   64'(bus.m_req),   64'h0);
    chk("sp_i_ready", 64'(bus.i_ready), 64'h0);
    chk("sp_d_ready", 64'(bus.d_ready), 64'h0);
    chk("sp_i_rdata", 64'(bus.i_rdata), 64'hAA);
    bus.m_ack = 1'b0;
    tick();
    chk("sp_idle_still", 64'(bus.m_req), 64'h0);

    // Reset while in BUS
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0300;
    tick();
    chk("rb_m_req", 64'(bus.m_req), 64'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("rb_async_drop", 64'(bus.m_req), 64'h0);
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h99;
    tick();
    chk("rb_no_ready", 64'(bus.i_ready), 64'h0);
    bus.m_ack = 1'b0;
    reset = 1'b1;
    tick();
    chk("rb_regrant",      64'(bus.m_req),  64'h1);
    chk("rb_regrant_addr", 64'(bus.m_addr), 64'h300);
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h77;
    tick();
    chk("rb_i_ready", 64'(bus.i_ready), 64'h1);
    chk("rb_i_rdata", 64'(bus.i_rdata), 64'h77);
    bus.m_ack = 1'b0;
    bus.i_req = 1'b0;
    tick();

    // Continuous D and I requests: grant order
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_0400;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0500;
    for (int k = 0; k < 6; k++) begin
      tick();
`ifdef ARB_STARVE_EN
      exp_addr = (k == 4) ? 32'h500 : 32'h400;
`else
      exp_addr = 32'h400;
`endif
      chk("sv_grant_addr", 64'(bus.m_addr), 64'(exp_addr));
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'(k);
      tick();
      bus.m_ack = 1'b0;
      tick();
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    tick();
    tick();
    chk("end_idle", 64'(bus.m_req), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
